// File: rtl/song_player.sv
// Auto-play sequencer: walks a song ROM and drives note/pitch/stop to the Buzzer stage.
// Latency: start -> first note on the outputs 3 cycles later; abort -> IDLE outputs next cycle.
// Backpressure: none; pause (level) freezes the PLAY/GAP timers and raises stop while held.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        1-cycle control pulses from the mode controller
//   pause               level, freezes playback in PLAY/GAP
//   rom_addr, rom_data  song ROM port; data valid one cycle after the address changes
//                       rom_data[6:0]=note one-hot, [9:7]=pitch one-hot, [13:10]=beats
//   note, pitch, stop   Buzzer drive (stop=1 freezes the Buzzer)
//   busy, done          status: busy outside IDLE, done pulses on normal end of song
module song_player #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [13:0]       rom_data,
    output logic [6:0]        note,
    output logic [2:0]        pitch,
    output logic              stop,
    output logic              busy,
    output logic              done
);

    localparam int TICK_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [2:0]        PITCH_MID = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [6:0]        r_note,  w_note_nxt;
    logic [2:0]        r_pitch, w_pitch_nxt;
    logic              r_stop,  w_stop_nxt;
    logic              r_busy,  w_busy_nxt;
    logic              r_done,  w_done_nxt;
    logic [TICK_W-1:0] r_tick,  w_tick_nxt;
    logic [3:0]        r_beats, w_beats_nxt;
    logic [GAP_W-1:0]  r_gap,   w_gap_nxt;

    logic [3:0] w_rom_beats;
    logic [2:0] w_rom_pitch;
    logic       w_pitch_ok;

    assign w_rom_beats = rom_data[13:10];
    assign w_rom_pitch = rom_data[9:7];
    // Anything that is not a clean one-hot pitch falls back to the middle octave.
    assign w_pitch_ok  = (w_rom_pitch == 3'b001) || (w_rom_pitch == 3'b010) ||
                         (w_rom_pitch == 3'b100);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_note  <= '0;
            r_pitch <= PITCH_MID;
            r_stop  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tick  <= '0;
            r_beats <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_note  <= w_note_nxt;
            r_pitch <= w_pitch_nxt;
            r_stop  <= w_stop_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_tick  <= w_tick_nxt;
            r_beats <= w_beats_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_note_nxt  = r_note;
        w_pitch_nxt = r_pitch;
        w_stop_nxt  = r_stop;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_tick_nxt  = r_tick;
        w_beats_nxt = r_beats;
        w_gap_nxt   = r_gap;

        if (abort) begin
            // Abort overrides start, pause and any transition of the current state.
            w_state_nxt = S_IDLE;
            w_addr_nxt  = '0;
            w_note_nxt  = '0;
            w_stop_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_tick_nxt  = '0;
            w_beats_nxt = '0;
            w_gap_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_note_nxt = '0;
                    w_stop_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                    if (start) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_FETCH: begin
                    w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (w_rom_beats == 4'd0) begin
                        // Zero beats marks the end of the song.
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                        w_note_nxt  = '0;
                        w_stop_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_note_nxt  = rom_data[6:0];
                        w_pitch_nxt = w_pitch_ok ? w_rom_pitch : PITCH_MID;
                        w_beats_nxt = w_rom_beats;
                        w_tick_nxt  = '0;
                        w_stop_nxt  = 1'b0;
                    end
                end
                S_PLAY: begin
                    w_stop_nxt = pause;
                    if (!pause) begin
                        if (r_tick == TICK_LAST) begin
                            w_tick_nxt = '0;
                            if (r_beats == 4'd1) begin
                                w_state_nxt = S_GAP;
                                w_gap_nxt   = '0;
                                w_note_nxt  = '0;
                            end else begin
                                w_beats_nxt = r_beats - 1'b1;
                            end
                        end else begin
                            w_tick_nxt = r_tick + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    w_stop_nxt = pause;
                    if (!pause) begin
                        if (r_gap == GAP_LAST) begin
                            // The last ROM slot ends the song instead of wrapping to entry 0.
                            if (r_addr == ADDR_LAST) begin
                                w_state_nxt = S_FINISH;
                                w_done_nxt  = 1'b1;
                                w_stop_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_FETCH;
                                w_addr_nxt  = r_addr + 1'b1;
                            end
                        end else begin
                            w_gap_nxt = r_gap + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    w_state_nxt = S_IDLE;
                    w_note_nxt  = '0;
                    w_stop_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign rom_addr = r_addr;
    assign note     = r_note;
    assign pitch    = r_pitch;
    assign stop     = r_stop;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
